sort_floats_stream: RTL

Streaming counterpart of the combinational float sorters. The block receives a packet of `N` FLEN-bit floating-point words one per handshake on an upstream valid/ready port and sorts them in place using a single `f_less_or_equal` instance over several cycles. It then transmits them in increasing order, one per handshake, on a downstream valid/ready port. It sits between a serial FP producer and a consumer that needs ordered operands, and costs one comparator instead of a comparator network.

---
 rtl/f_less_or_equal.sv | 45 ++++
 rtl/sort_floats_stream.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/f_less_or_equal.sv
// Combinational IEEE-754 a <= b comparator.
//   a, b : FLEN-bit operands (binary32 when FLEN==32, otherwise binary64)
//   res  : 1 when a <= b; -0.0 and +0.0 compare equal; 0 whenever err is set
//   err  : 1 when either operand is a NaN
module f_less_or_equal #(
  parameter int unsigned FLEN = 64
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);

  localparam int unsigned EXP_W = (FLEN == 32) ? 8 : 11;
  localparam int unsigned MAN_W = FLEN - 1 - EXP_W;

  logic            a_sign, b_sign, a_nan, b_nan, both_zero;
  logic [FLEN-2:0] a_mag, b_mag;

  assign a_sign    = a[FLEN-1];
  assign b_sign    = b[FLEN-1];
  assign a_mag     = a[FLEN-2:0];
  assign b_mag     = b[FLEN-2:0];
  assign a_nan     = (&a[FLEN-2 -: EXP_W]) && (|a[MAN_W-1:0]);
  assign b_nan     = (&b[FLEN-2 -: EXP_W]) && (|b[MAN_W-1:0]);
  assign both_zero = (a_mag == '0) && (b_mag == '0);

  // Sign-magnitude ordering; negative magnitudes order in reverse.
  always_comb begin
    err = a_nan || b_nan;
    res = 1'b0;
    if (err) begin
      res = 1'b0;
    end else if (both_zero) begin
      res = 1'b1;
    end else if (a_sign != b_sign) begin
      res = a_sign;
    end else if (!a_sign) begin
      res = (a_mag <= b_mag);
    end else begin
      res = (a_mag >= b_mag);
    end
  end

endmodule

// File: rtl/sort_floats_stream.sv
// Streaming packet sorter: collects N FLEN-bit floats, bubble-sorts them in
// place with one shared comparator, then emits them in increasing order.
//   clk, rst            : clock, synchronous active-low reset
//   up_valid/up_ready   : upstream word handshake, up_data is the word
//   down_valid/ready    : downstream handshake, down_data is the sorted word
//   down_last           : marks the N-th (largest) word of a packet
//   down_err            : a NaN compare occurred while sorting this packet
module sort_floats_stream #(
  parameter int unsigned N    = 3,
  parameter int unsigned FLEN = 64   // matches the shared FP configuration
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [FLEN-1:0] up_data,
  output logic            down_valid,
  input  logic            down_ready,
  output logic [FLEN-1:0] down_data,
  output logic            down_last,
  output logic            down_err
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(N - 2);

  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_SORT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [FLEN-1:0]  word_buf [N];
  logic [IDX_W-1:0] idx, pass_cnt, step, step_p1;
  logic             err_acc;
  logic             cmp_res, cmp_err;
  logic             sort_done;

  assign step_p1   = step + IDX_W'(1);
  assign sort_done = (step == LAST_STEP) && (pass_cnt == LAST_STEP);

  // The single comparator always looks at the current adjacent pair.
  f_less_or_equal #(.FLEN(FLEN)) u_cmp (
    .a   (word_buf[step]),
    .b   (word_buf[step_p1]),
    .res (cmp_res),
    .err (cmp_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_RECV;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and port decode; ports depend only on registered state.
  always_comb begin
    state_nxt  = state;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    down_data  = '0;
    down_last  = 1'b0;
    down_err   = 1'b0;
    case (state)
      S_RECV: begin
        up_ready = 1'b1;
        if (up_valid && (idx == LAST_IDX)) begin
          state_nxt = S_SORT;
        end
      end
      S_SORT: begin
        // Fixed (N-1)*(N-1) cycles; no early exit.
        if (sort_done) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        down_valid = 1'b1;
        down_data  = word_buf[idx];
        down_last  = (idx == LAST_IDX);
        down_err   = err_acc;
        if (down_ready && (idx == LAST_IDX)) begin
          state_nxt = S_RECV;
        end
      end
      default: state_nxt = S_RECV;
    endcase
  end

  // Packet storage, counters and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx      <= '0;
      pass_cnt <= '0;
      step     <= '0;
      err_acc  <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        word_buf[i] <= '0;
      end
    end else begin
      case (state)
        S_RECV: begin
          if (up_valid) begin
            word_buf[idx] <= up_data;
            if (idx == LAST_IDX) begin
              idx      <= '0;
              step     <= '0;
              pass_cnt <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_SORT: begin
          // Swap only on a strict out-of-order pair: equal keys keep arrival order.
          if (cmp_err) begin
            err_acc <= 1'b1;
          end else if (!cmp_res) begin
            word_buf[step]    <= word_buf[step_p1];
            word_buf[step_p1] <= word_buf[step];
          end
          if (step == LAST_STEP) begin
            step     <= '0;
            pass_cnt <= pass_cnt + IDX_W'(1);
          end else begin
            step <= step_p1;
          end
        end
        S_SEND: begin
          if (down_ready) begin
            if (idx == LAST_IDX) begin
              idx     <= '0;
              err_acc <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
